// File: rtl/interface_sensor_pkg.sv
// Shared types and helpers for the sensor-poll interface: FSM state codes,
// receiver states, parity-mode constants and width helpers.
package interface_sensor_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    TRIGGER = 4'd1,
    WAIT    = 4'd2,
    CHECK   = 4'd3,
    LOAD    = 4'd4,
    RETRY   = 4'd5,
    FAIL    = 4'd6
  } state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic int frame_w(input int n_fields, input int field_w);
    return n_fields * field_w;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/interface_sensor_poll_fd_rx.sv
// sensor_frame_rx: serial frame receiver (start, DATA_W bits LSB first, parity, stop),
// mid-bit sampling; synchronous clear holds it idle.
module sensor_frame_rx
  import interface_sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 32,
  parameter int PARITY       = PAR_ODD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              parity_ok,
  output logic              fim
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          PAR_SENSE = (PARITY == PAR_ODD);

  rx_state_t         r_st;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bits;
  logic [DATA_W-1:0] r_data;
  logic              r_par;
  logic              r_pok;
  logic              r_fim;
  logic              r_s0;
  logic              r_s1;
  logic              w_rxd;

  // Two-flop synchroniser; idles high so a reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      r_s0 <= rxd;
      r_s1 <= r_s0;
    end
  end

  assign w_rxd = r_s1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st   <= RX_IDLE;
      r_cnt  <= '0;
      r_bits <= '0;
      r_data <= '0;
      r_par  <= 1'b0;
      r_pok  <= 1'b0;
      r_fim  <= 1'b0;
    end else if (clear) begin
      r_st   <= RX_IDLE;
      r_cnt  <= '0;
      r_bits <= '0;
      r_data <= '0;
      r_par  <= 1'b0;
      r_pok  <= 1'b0;
      r_fim  <= 1'b0;
    end else begin
      r_fim <= 1'b0;
      case (r_st)
        RX_IDLE: begin
          r_cnt  <= '0;
          r_bits <= '0;
          if (!w_rxd) r_st <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_END) begin
            r_cnt <= '0;
            r_st  <= w_rxd ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == BIT_END) begin
            r_cnt  <= '0;
            r_data <= {w_rxd, r_data[DATA_W-1:1]};
            if (r_bits == LAST_BIT) r_st <= RX_PAR;
            else                    r_bits <= r_bits + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_PAR: begin
          if (r_cnt == BIT_END) begin
            r_cnt <= '0;
            r_par <= w_rxd;
            r_st  <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == BIT_END) begin
            r_cnt <= '0;
            r_fim <= 1'b1;
            // A missing stop bit is folded into the parity verdict.
            r_pok <= ((^{r_data, r_par}) == PAR_SENSE) && w_rxd;
            r_st  <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_st <= RX_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign parity_ok = r_pok;
  assign fim       = r_fim;

endmodule

// File: rtl/interface_sensor_poll_fd.sv
// Sensor poll controller: request pulse, one serial frame of NUM_FIELDS x FIELD_W bits,
// parity/timeout retry, atomic field latch. Optional macro AUTO_POLL_EN adds a periodic start.
module interface_sensor_poll_fd
  import interface_sensor_pkg::*;
#(
  parameter int CLOCK_HZ       = 50_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int FIELD_W        = 16,
  parameter int NUM_FIELDS     = 2,
  parameter int PARITY         = PAR_ODD,
  parameter int TRIG_CYCLES    = 1250,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_RETRY      = 3,
  parameter int POLL_CYCLES    = 50_000_000
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      rx_serial,
  output logic                                      trigger_out,
  output logic                                      busy,
  output logic                                      data_valid,
  output logic [frame_w(NUM_FIELDS, FIELD_W)-1:0]   fields_out,
  output logic                                      parity_err,
  output logic                                      timeout_err,
  output logic                                      fail,
  output logic [cnt_w(MAX_RETRY+1)-1:0]             retry_count,
  output logic [3:0]                                db_estado
);

  localparam int FW  = frame_w(NUM_FIELDS, FIELD_W);
  localparam int RW  = cnt_w(MAX_RETRY + 1);
  localparam int TW  = cnt_w(TRIG_CYCLES);
  localparam int OW  = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TRIG_END  = TW'(TRIG_CYCLES - 1);
  localparam logic [OW-1:0] TO_END    = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t        r_state;
  logic          r_trig;
  logic          r_busy;
  logic          r_valid;
  logic          r_fail;
  logic          r_perr;
  logic          r_terr;
  logic [FW-1:0] r_fields;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tcnt;
  logic [OW-1:0] r_tocnt;

  logic          w_start;
  logic          w_clear;
  logic [FW-1:0] w_frame;
  logic          w_par_ok;
  logic          w_fim;

`ifdef AUTO_POLL_EN
  localparam int PW = cnt_w(POLL_CYCLES);
  localparam logic [PW-1:0] POLL_END = PW'(POLL_CYCLES - 1);

  logic [PW-1:0] r_poll_cnt;
  logic          w_poll_hit;

  assign w_poll_hit = (r_state == IDLE) && (r_poll_cnt == POLL_END);

  // Counts only idle cycles; any excursion out of IDLE restarts the period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                r_poll_cnt <= '0;
    else if ((r_state != IDLE) || w_poll_hit)  r_poll_cnt <= '0;
    else                                       r_poll_cnt <= r_poll_cnt + 1'b1;
  end

  assign w_start = start | w_poll_hit;
`else
  assign w_start = start;
`endif

  // The receiver only listens while waiting for the answer.
  assign w_clear = (r_state != WAIT);

  sensor_frame_rx #(
    .CLKS_PER_BIT (CLOCK_HZ / BAUD_RATE),
    .DATA_W       (FW),
    .PARITY       (PARITY)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_clear),
    .rxd       (rx_serial),
    .data      (w_frame),
    .parity_ok (w_par_ok),
    .fim       (w_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_trig   <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_fail   <= 1'b0;
      r_perr   <= 1'b0;
      r_terr   <= 1'b0;
      r_fields <= '0;
      r_retry  <= '0;
      r_tcnt   <= '0;
      r_tocnt  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_fail  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= TRIGGER;
            r_trig  <= 1'b1;
            r_busy  <= 1'b1;
            r_perr  <= 1'b0;
            r_terr  <= 1'b0;
            r_retry <= '0;
            r_tcnt  <= '0;
          end
        end
        TRIGGER: begin
          if (r_tcnt == TRIG_END) begin
            r_state <= WAIT;
            r_trig  <= 1'b0;
            r_tocnt <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        WAIT: begin
          // A frame completing on the timeout cycle still gets checked.
          if (w_fim) begin
            r_state <= CHECK;
          end else if (r_tocnt == TO_END) begin
            r_state <= RETRY;
            r_terr  <= 1'b1;
          end else begin
            r_tocnt <= r_tocnt + 1'b1;
          end
        end
        CHECK: begin
          if (w_par_ok) begin
            r_state  <= LOAD;
            r_fields <= w_frame;
            r_valid  <= 1'b1;
          end else begin
            r_state <= RETRY;
            r_perr  <= 1'b1;
          end
        end
        LOAD: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        RETRY: begin
          if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + 1'b1;
            r_state <= TRIGGER;
            r_trig  <= 1'b1;
            r_tcnt  <= '0;
          end else begin
            r_state <= FAIL;
            r_fail  <= 1'b1;
          end
        end
        FAIL: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_trig  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign trigger_out = r_trig;
  assign busy        = r_busy;
  assign data_valid  = r_valid;
  assign fields_out  = r_fields;
  assign parity_err  = r_perr;
  assign timeout_err = r_terr;
  assign fail        = r_fail;
  assign retry_count = r_retry;
  assign db_estado   = r_state;

endmodule

// File: tb/tb_interface_sensor_poll_fd.sv
// Directed bench for interface_sensor_poll_fd: a bench-driven sensor answers each request
// with a hand-built frame; pulse counts and latched outputs are checked against fixed values.
module tb_interface_sensor_poll_fd;

  localparam int CPB = 10;  // 96 kHz / 9600 baud

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx;
  logic        trigger_out;
  logic        busy;
  logic        data_valid;
  logic [31:0] fields_out;
  logic        parity_err;
  logic        timeout_err;
  logic        fail;
  logic [1:0]  retry_count;
  logic [3:0]  db_estado;

  int n_vec = 0;
  int n_err = 0;

  interface_sensor_poll_fd #(
    .CLOCK_HZ       (96_000),
    .BAUD_RATE      (9600),
    .FIELD_W        (16),
    .NUM_FIELDS     (2),
    .PARITY         (1),
    .TRIG_CYCLES    (20),
    .TIMEOUT_CYCLES (2000),
    .MAX_RETRY      (2),
    .POLL_CYCLES    (5000)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .rx_serial   (rx),
    .trigger_out (trigger_out),
    .busy        (busy),
    .data_valid  (data_valid),
    .fields_out  (fields_out),
    .parity_err  (parity_err),
    .timeout_err (timeout_err),
    .fail        (fail),
    .retry_count (retry_count),
    .db_estado   (db_estado)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int n_trig = 0;
  int n_valid = 0;
  int n_fail = 0;
  int cur_len = 0;
  int last_len = 0;
  int t_rise = 0;
  int t_idle = 0;
  logic p_trig = 1'b0;
  logic p_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (trigger_out && !p_trig) begin
      n_trig  <= n_trig + 1;
      t_rise  <= cyc;
      cur_len <= 1;
    end else if (trigger_out) begin
      cur_len <= cur_len + 1;
    end
    if (!trigger_out && p_trig) last_len <= cur_len;
    if (data_valid) n_valid <= n_valid + 1;
    if (fail)       n_fail  <= n_fail + 1;
    if (!busy && p_busy) t_idle <= cyc;
    p_trig <= trigger_out;
    p_busy <= busy;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mk_frame(input logic [31:0] d, input logic bad);
    logic p;
    p = ~(^d) ^ bad;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_sym(input logic [34:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      rx = v[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_trig_fall(input string tag);
    logic seen_hi;
    logic found;
    int unsigned n;
    seen_hi = trigger_out;
    found   = 1'b0;
    n       = 0;
    while (!found && n < 8000) begin
      @(negedge clk);
      n++;
      if (trigger_out)  seen_hi = 1'b1;
      else if (seen_hi) found = 1'b1;
    end
    chk(tag, found, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int unsigned limit);
    logic found;
    int unsigned n;
    found = 1'b0;
    n     = 0;
    while (!found && n < limit) begin
      if (!busy) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk(tag, found, 1'b1);
  endtask

  int b_trig, b_valid, b_fail, t_idle1;

  task automatic snap();
    b_trig  = n_trig;
    b_valid = n_valid;
    b_fail  = n_fail;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    rx    = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_trig",  trigger_out, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_field", fields_out, 0);
    chk("rst_perr",  parity_err, 0);
    chk("rst_terr",  timeout_err, 0);
    chk("rst_fail",  fail, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_state", db_estado, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1: clean capture
    snap();
    pulse_start();
    chk("t1_busy",  busy, 1);
    chk("t1_state", db_estado, 1);
    wait_trig_fall("t1_trig_fall");
    chk("t1_wait_state", db_estado, 2);
    send_sym(mk_frame(32'h01F4_0258, 1'b0), 35);
    wait_idle("t1_done", 200);
    repeat (2) @(negedge clk);
    chk("t1_trig_len", last_len, 20);
    chk("t1_ntrig",  n_trig - b_trig, 1);
    chk("t1_nvalid", n_valid - b_valid, 1);
    chk("t1_fields", fields_out, 32'h01F4_0258);
    chk("t1_perr",   parity_err, 0);
    chk("t1_terr",   timeout_err, 0);
    chk("t1_retry",  retry_count, 0);

    // 2: bad parity, then good frame on the retry
    snap();
    pulse_start();
    wait_trig_fall("t2_trig_fall_a");
    send_sym(mk_frame(32'h0000_1234, 1'b1), 35);
    chk("t2_fields_hold", fields_out, 32'h01F4_0258);
    wait_trig_fall("t2_trig_fall_b");
    send_sym(mk_frame(32'h0000_1234, 1'b0), 35);
    wait_idle("t2_done", 200);
    repeat (2) @(negedge clk);
    chk("t2_ntrig",  n_trig - b_trig, 2);
    chk("t2_retry",  retry_count, 1);
    chk("t2_perr",   parity_err, 1);
    chk("t2_terr",   timeout_err, 0);
    chk("t2_nvalid", n_valid - b_valid, 1);
    chk("t2_fields", fields_out, 32'h0000_1234);

    // 3: silent line, retries exhausted
    snap();
    pulse_start();
    wait_idle("t3_done", 8000);
    repeat (2) @(negedge clk);
    chk("t3_ntrig",  n_trig - b_trig, 3);
    chk("t3_nfail",  n_fail - b_fail, 1);
    chk("t3_nvalid", n_valid - b_valid, 0);
    chk("t3_retry",  retry_count, 2);
    chk("t3_terr",   timeout_err, 1);
    chk("t3_perr",   parity_err, 0);
    chk("t3_fields", fields_out, 32'h0000_1234);

    // 4: reset in the middle of the frame
    pulse_start();
    wait_trig_fall("t4_trig_fall");
    send_sym(mk_frame(32'hDEAD_BEEF, 1'b0), 11);
    chk("t4_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t4_busy",  busy, 0);
    chk("t4_trig",  trigger_out, 0);
    chk("t4_state", db_estado, 0);
    chk("t4_field", fields_out, 0);
    chk("t4_retry", retry_count, 0);
    chk("t4_terr",  timeout_err, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    snap();
    pulse_start();
    wait_trig_fall("t4_trig_fall_b");
    send_sym(mk_frame(32'hA5C3_0F1E, 1'b0), 35);
    wait_idle("t4_done", 200);
    repeat (2) @(negedge clk);
    chk("t4_nvalid", n_valid - b_valid, 1);
    chk("t4_fields", fields_out, 32'hA5C3_0F1E);

    // 5: start held through WAIT and the LOAD cycle is ignored
    snap();
    pulse_start();
    wait_trig_fall("t5_trig_fall");
    @(negedge clk);
    start = 1'b1;
    fork
      send_sym(mk_frame(32'h0BAD_F00D, 1'b0), 35);
      begin : t5_release
        int unsigned n;
        n = 0;
        while (db_estado != 4'd4 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        chk("t5_load_seen", db_estado, 4);
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("t5_busy",   busy, 0);
    chk("t5_state",  db_estado, 0);
    chk("t5_ntrig",  n_trig - b_trig, 1);
    chk("t5_nvalid", n_valid - b_valid, 1);
    chk("t5_fields", fields_out, 32'h0BAD_F00D);

`ifdef AUTO_POLL_EN
    // 6: periodic self-start
    snap();
    wait_trig_fall("t6_poll_a");
    send_sym(mk_frame(32'h1111_2222, 1'b0), 35);
    wait_idle("t6_done_a", 200);
    repeat (2) @(negedge clk);
    t_idle1 = t_idle;
    chk("t6_fields_a", fields_out, 32'h1111_2222);
    wait_trig_fall("t6_poll_b");
    send_sym(mk_frame(32'h3333_4444, 1'b0), 35);
    wait_idle("t6_done_b", 200);
    repeat (2) @(negedge clk);
    chk("t6_gap",      t_rise - t_idle1, 5000);
    chk("t6_nvalid",   n_valid - b_valid, 2);
    chk("t6_fields_b", fields_out, 32'h3333_4444);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
